// File: rtl/shk_uart_arbiter.sv
// ---------------------------------------------------------------------------
// shk_uart_arbiter
//
// Two-requester round-robin arbiter in front of a slow UART-style shake
// transmitter. Each granted transaction is sent as an address phase
// (m_shk_wr_valid strobe) followed by a data phase (m_shk_wr_msync strobe).
// Each phase reserves at least NB_BYTE_CYC cycles and then waits for
// m_shk_wr_ready before moving on. The granted requester gets a one-cycle ack.
//
// Optional feature (macro SHK_ARB_TIMEOUT_EN): a watchdog that abandons a
// phase stuck on m_shk_wr_ready=0 for NB_TIMEOUT cycles. It acks anyway and
// records the failure in sticky m_err_arb_info bits. When the macro is not
// defined, the wait states wait indefinitely and m_err_arb_info is 0.
//
// Ports
//   i_sys_clk, i_sys_reset     : clock, synchronous active-high reset
//   sN_req_valid/addr/data     : level request from requester N (N=0,1)
//   sN_req_ack                 : one-cycle completion pulse to requester N
//   m_shk_wr_valid/maddr       : address-phase strobe and latched address
//   m_shk_wr_msync/mdata       : data-phase strobe and latched data
//   m_shk_wr_ready             : downstream transmitter idle
//   o_busy, o_grant            : transaction in flight, one-hot owner
//   m_err_arb_info             : [0] addr timeout, [1] data timeout,
//                                [3:2] one-hot owner that timed out
// ---------------------------------------------------------------------------
module shk_uart_arbiter #(
  parameter int WD_SHK_DATA = 8,
  parameter int WD_SHK_ADDR = 8,
  parameter int NB_BYTE_CYC = 8680,
  parameter int NB_TIMEOUT  = 65536
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_reset,
  input  logic                   s0_req_valid,
  input  logic [WD_SHK_ADDR-1:0] s0_req_addr,
  input  logic [WD_SHK_DATA-1:0] s0_req_data,
  output logic                   s0_req_ack,
  input  logic                   s1_req_valid,
  input  logic [WD_SHK_ADDR-1:0] s1_req_addr,
  input  logic [WD_SHK_DATA-1:0] s1_req_data,
  output logic                   s1_req_ack,
  output logic                   m_shk_wr_valid,
  output logic                   m_shk_wr_msync,
  output logic [WD_SHK_ADDR-1:0] m_shk_wr_maddr,
  output logic [WD_SHK_DATA-1:0] m_shk_wr_mdata,
  input  logic                   m_shk_wr_ready,
  output logic                   o_busy,
  output logic [1:0]             o_grant,
  output logic [3:0]             m_err_arb_info
);

  // Elaboration-time parameter sanity.
  if (NB_BYTE_CYC < 2) begin : g_bad_byte_cyc
    $error("NB_BYTE_CYC must be 2 or more");
  end
  if (NB_TIMEOUT < 1) begin : g_bad_timeout
    $error("NB_TIMEOUT must be 1 or more");
  end

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_WAIT = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_DATA_WAIT = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  // Counter only needs to hold NB_BYTE_CYC-1; it never wraps below zero.
  localparam int          CW       = $clog2(NB_BYTE_CYC);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NB_BYTE_CYC - 1);

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             grant_q, grant_d;
  logic [WD_SHK_ADDR-1:0] addr_q, addr_d;
  logic [WD_SHK_DATA-1:0] data_q, data_d;
  logic                   last_q, last_d;   // 1: s1 was served last
  logic                   pick_s1;
  logic                   cnt_zero;

`ifdef SHK_ARB_TIMEOUT_EN
  localparam int           WDW    = $clog2(NB_TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(NB_TIMEOUT - 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic [3:0]     err_q, err_d;
`endif

  // Round robin: with both requesting, the one not served last wins.
  assign pick_s1  = s1_req_valid & (~s0_req_valid | ~last_q);
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef SHK_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (s0_req_valid | s1_req_valid) begin
          grant_d = pick_s1 ? 2'b10 : 2'b01;
          addr_d  = pick_s1 ? s1_req_addr : s0_req_addr;
          data_d  = pick_s1 ? s1_req_data : s0_req_data;
          state_d = S_ADDR;
        end
      end
      S_ADDR, S_DATA: begin
        cnt_d   = CNT_LOAD;
        state_d = (state_q == S_ADDR) ? S_ADDR_WAIT : S_DATA_WAIT;
`ifdef SHK_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_ADDR_WAIT, S_DATA_WAIT: begin
        if (!cnt_zero) cnt_d = cnt_q - CW'(1);
        if (cnt_zero && m_shk_wr_ready) begin
          state_d = (state_q == S_ADDR_WAIT) ? S_DATA : S_DONE;
        end
`ifdef SHK_ARB_TIMEOUT_EN
        else if (!m_shk_wr_ready) begin
          // This cycle is the NB_TIMEOUT-th stalled one: give up on the phase.
          if (wd_q == WD_LAST) begin
            state_d    = S_DONE;
            err_d[3:2] = err_q[3:2] | grant_q;
            if (state_q == S_ADDR_WAIT) err_d[0] = 1'b1;
            else                        err_d[1] = 1'b1;
          end else begin
            wd_d = wd_q + WDW'(1);
          end
        end
`endif
      end
      S_DONE: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b1;
`ifdef SHK_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 4'b0000;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef SHK_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // Outputs decode registered state only, so reset clears them in one edge.
  assign o_busy         = (state_q != S_IDLE);
  assign o_grant        = grant_q;
  assign m_shk_wr_valid = (state_q == S_ADDR);
  assign m_shk_wr_msync = (state_q == S_DATA);
  assign m_shk_wr_maddr = addr_q;
  assign m_shk_wr_mdata = data_q;
  assign s0_req_ack     = (state_q == S_DONE) & grant_q[0];
  assign s1_req_ack     = (state_q == S_DONE) & grant_q[1];
`ifdef SHK_ARB_TIMEOUT_EN
  assign m_err_arb_info = err_q;
`else
  assign m_err_arb_info = 4'b0000;
`endif

endmodule

// File: doc/shk_uart_arbiter.md
SHK_UART_ARBITER -- requirements
Module: shk_uart_arbiter

Interface
REQ-001 SHALL have parameter WD_SHK_DATA, default 8, data byte width.
REQ-002 SHALL have parameter WD_SHK_ADDR, default 8, address width.
REQ-003 SHALL have parameter NB_BYTE_CYC, default 8680, minimum clock cycles reserved per UART frame; legal range 2 or more.
REQ-004 SHALL have parameter NB_TIMEOUT, default 65536, watchdog limit in cycles; used only with SHK_ARB_TIMEOUT_EN.
REQ-005 SHALL have port i_sys_clk, input, 1 bit: the single clock. All logic is clocked on its rising edge.
REQ-006 SHALL have port i_sys_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports s0_req_valid and s1_req_valid, input, 1 bit each: level request, held high until the matching ack.
REQ-008 SHALL have ports s0_req_addr and s1_req_addr, input, WD_SHK_ADDR bits each: transaction address.
REQ-009 SHALL have ports s0_req_data and s1_req_data, input, WD_SHK_DATA bits each: transaction data.
REQ-010 SHALL have ports s0_req_ack and s1_req_ack, output, 1 bit each: one-cycle completion pulse.
REQ-011 SHALL have ports m_shk_wr_valid and m_shk_wr_msync, output, 1 bit each: downstream address-phase and data-phase strobes.
REQ-012 SHALL have ports m_shk_wr_maddr (output, WD_SHK_ADDR bits) and m_shk_wr_mdata (output, WD_SHK_DATA bits): downstream address and data.
REQ-013 SHALL have port m_shk_wr_ready, input, 1 bit: downstream transmitter idle.
REQ-014 SHALL have ports o_busy (output, 1 bit) and o_grant (output, 2 bits, one-hot): status.
REQ-015 SHALL have port m_err_arb_info, output, 4 bits: error status.

Function
REQ-016 SHALL implement states IDLE, ADDR, ADDR_WAIT, DATA, DATA_WAIT, DONE.
REQ-017 In IDLE with at least one request high, SHALL grant, latch the granted addr/data into registers, and enter ADDR on the next edge.
REQ-018 Grant SHALL be round-robin: when both requests are high, the requester not granted last wins. After reset, s0 has priority.
REQ-019 ADDR SHALL drive m_shk_wr_valid=1 for exactly one cycle; the strobe is asserted in the cycle following request sampling (latency 1).
REQ-020 ADDR and DATA SHALL load a wait counter with NB_BYTE_CYC-1. The counter SHALL be sized as ceil(log2(NB_BYTE_CYC)) bits, with no wrap.
REQ-021 ADDR_WAIT SHALL decrement the counter each cycle and leave only when counter==0 and m_shk_wr_ready==1; it then enters DATA.
REQ-022 DATA SHALL drive m_shk_wr_msync=1 for exactly one cycle, then enter DATA_WAIT.
REQ-023 DATA_WAIT SHALL use the same exit rule as ADDR_WAIT, then enter DONE.
REQ-024 DONE SHALL pulse the granted sN_req_ack for one cycle, update the last-grant record, and return to IDLE. No new grant is issued in the DONE cycle.
REQ-025 m_shk_wr_maddr and m_shk_wr_mdata SHALL hold the latched values from grant until the next grant. Later changes on requester inputs SHALL be ignored.
REQ-026 If the granted request drops mid-transaction, the transaction SHALL still complete and the ack SHALL still pulse.
REQ-027 o_busy SHALL be 1 in every state except IDLE. o_grant SHALL be nonzero only while o_busy=1.
REQ-028 A request arriving during a transaction SHALL wait. It is serviced from the IDLE cycle after DONE, so the minimum gap between transactions is 2 cycles.

Reset
REQ-029 With i_sys_reset=1 at an edge, the state SHALL go to IDLE and all outputs to 0: strobes, acks, o_busy, o_grant, maddr, mdata and m_err_arb_info. Last-grant SHALL be set to s1, so that s0 wins first.
REQ-030 Reset asserted mid-transaction SHALL abort it with no ack and no further strobe.

Configuration
REQ-031 With macro SHK_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in ADDR_WAIT/DATA_WAIT while m_shk_wr_ready=0.
REQ-032 When that count reaches NB_TIMEOUT, the block SHALL go to DONE and ack. It SHALL set sticky bit m_err_arb_info[0] (address phase) or [1] (data phase), and set [3:2] to the one-hot grant of the failing requester. The bits are cleared only by reset.
REQ-033 Without SHK_ARB_TIMEOUT_EN, the wait states SHALL wait indefinitely and m_err_arb_info SHALL be constant 0.

Verification (NB_BYTE_CYC=4, NB_TIMEOUT=16)
REQ-034 s0 request only, addr 0x12, data 0x34, ready tied 1 -> valid at T+1 with maddr 0x12, msync at T+6 with mdata 0x34, s0_req_ack at T+11, single pulse each.
REQ-035 Both requests raised in the same cycle and held -> s0 served, then s1 starting 2 cycles after the s0 ack, then s0 again.
REQ-036 Ready held 0 for 20 cycles after the valid strobe -> msync is asserted only after ready returns high, and no strobe is repeated.
REQ-037 Requester changes addr/data and drops its request during ADDR_WAIT -> latched values are still transmitted and the ack still pulses.
REQ-038 Reset asserted in DATA_WAIT -> next cycle all outputs are 0 and no ack occurs; a fresh s1 request afterwards is granted with o_grant=2'b10.
REQ-039 With SHK_ARB_TIMEOUT_EN defined and ready stuck at 0 -> ack pulses after 16 waiting cycles and m_err_arb_info=4'b0101 for s0 failing in the address phase.
